stream_fifo_arbiter: RTL and testbench

STREAM_FIFO_ARBITER -- requirements
Module: stream_fifo_arbiter

---
 rtl/stream_fifo_arbiter.sv | 160 ++++++++++++++++
 tb/tb_stream_fifo_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo_arbiter.sv
// stream_fifo_arbiter
// Two-requester AXI-Stream arbiter feeding a downstream FIFO. Grants are
// round-robin and bounded to BURST beats. New beats stop while the FIFO
// occupancy is within HEADROOM of DEPTH. The output is a single register
// stage.
// Optional feature: define STREAM_FIFO_ARB_STATS_EN to add the 32-bit
// per-requester beat counters beats0 / beats1.
//
// Handshake: a beat moves on a port on the rising edge where TVALID and
// TREADY are both high. TVALID never waits on TREADY, and TDATA is held
// while TVALID is high and TREADY is low.
module stream_fifo_arbiter #(
   parameter int WIDTH    = 8,
   parameter int CNT_W    = 14,
   parameter int DEPTH    = 16384,
   parameter int HEADROOM = 4,
   parameter int BURST    = 16
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic [CNT_W-1:0] fifo_count,
   input  logic [WIDTH-1:0] in0_V_V_TDATA,
   input  logic             in0_V_V_TVALID,
   output logic             in0_V_V_TREADY,
   input  logic [WIDTH-1:0] in1_V_V_TDATA,
   input  logic             in1_V_V_TVALID,
   output logic             in1_V_V_TREADY,
   output logic [WIDTH-1:0] out_V_V_TDATA,
   output logic             out_V_V_TVALID,
   input  logic             out_V_V_TREADY,
   output logic [1:0]       grant,
   output logic [1:0]       state_dbg_o
`ifdef STREAM_FIFO_ARB_STATS_EN
   ,
   output logic [31:0]      beats0,
   output logic [31:0]      beats1
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   localparam logic [7:0]  BURST_LAST = 8'(BURST - 1);
   localparam logic [31:0] THRESH     = 32'(DEPTH - HEADROOM);

   state_t           state_q, state_d;
   logic             last_q, last_d;       // 1: requester 1 was served last
   logic [7:0]       burst_q, burst_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;

   logic throttle;
   logic can_take;
   logic acc0;
   logic acc1;

   // FIFO nearly full: block new beats, but keep the current grant
   assign throttle = (32'(fifo_count) >= THRESH);

   // Accept only when the output register is empty or draining this cycle
   assign can_take = !throttle && (!out_valid_q || out_V_V_TREADY);

   assign in0_V_V_TREADY = (state_q == G0) && can_take;
   assign in1_V_V_TREADY = (state_q == G1) && can_take;
   assign acc0           = in0_V_V_TREADY && in0_V_V_TVALID;
   assign acc1           = in1_V_V_TREADY && in1_V_V_TVALID;

   assign grant          = {state_q == G1, state_q == G0};
   assign state_dbg_o    = state_q;
   assign out_V_V_TDATA  = out_data_q;
   assign out_V_V_TVALID = out_valid_q;

   // Next-state logic: round-robin arbitration and bounded bursts
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      burst_d = burst_q;
      case (state_q)
         IDLE: begin
            if (in0_V_V_TVALID && (last_q || !in1_V_V_TVALID)) begin
               state_d = G0;
            end else if (in1_V_V_TVALID) begin
               state_d = G1;
            end
         end
         G0: begin
            if ((acc0 && (burst_q == BURST_LAST)) || !in0_V_V_TVALID) begin
               last_d  = 1'b0;
               state_d = in1_V_V_TVALID ? G1 : IDLE;
            end
         end
         G1: begin
            if ((acc1 && (burst_q == BURST_LAST)) || !in1_V_V_TVALID) begin
               last_d  = 1'b1;
               state_d = in0_V_V_TVALID ? G0 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) begin
         burst_d = '0;
      end else if (acc0 || acc1) begin
         burst_d = burst_q + 8'd1;
      end
   end

   // Output register: load on an accepted beat, empty when drained
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (acc0) begin
         out_valid_d = 1'b1;
         out_data_d  = in0_V_V_TDATA;
      end else if (acc1) begin
         out_valid_d = 1'b1;
         out_data_d  = in1_V_V_TDATA;
      end else if (out_V_V_TREADY) begin
         out_valid_d = 1'b0;
      end
   end

   // State and output registers; reset drops any registered beat
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         burst_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         burst_q     <= burst_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

`ifdef STREAM_FIFO_ARB_STATS_EN
   logic [31:0] beats0_q, beats1_q;

   // Wrapping per-requester counts of accepted beats
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         beats0_q <= '0;
         beats1_q <= '0;
      end else begin
         if (acc0) beats0_q <= beats0_q + 32'd1;
         if (acc1) beats1_q <= beats1_q + 32'd1;
      end
   end

   assign beats0 = beats0_q;
   assign beats1 = beats1_q;
`endif

endmodule

// File: tb/tb_stream_fifo_arbiter.sv
// Bench for stream_fifo_arbiter: table of throttle/backpressure vectors,
// grant-run tables, and hand sequences for stalls and mid-burst reset.
module tb_stream_fifo_arbiter;

   localparam int WIDTH = 8;
   localparam int CNT_W = 14;

   typedef struct {
      logic [CNT_W-1:0] fc;
      logic             ordy;
      logic             exp_r0;
      logic             exp_r1;
      logic [1:0]       exp_grant;
   } vec_t;

   typedef struct {
      logic [1:0] g;
      int         cycles;
      int         beats;
   } run_t;

   // clock / reset
   logic             ap_clk = 1'b0;
   logic             ap_rst = 1'b0;
   logic             clk_en = 1'b1;
   logic [CNT_W-1:0] fifo_count = '0;
   logic [WIDTH-1:0] in0_tdata = '0;
   logic             in0_tvalid = 1'b0;
   logic             in0_tready;
   logic [WIDTH-1:0] in1_tdata = '0;
   logic             in1_tvalid = 1'b0;
   logic             in1_tready;
   logic [WIDTH-1:0] out_tdata;
   logic             out_tvalid;
   logic             out_tready = 1'b1;
   logic [1:0]       grant;
   logic [1:0]       state_dbg;
`ifdef STREAM_FIFO_ARB_STATS_EN
   logic [31:0]      beats0, beats1;
`endif

   always begin
      #5;
      if (clk_en) ap_clk = ~ap_clk;
   end

   stream_fifo_arbiter dut (
      .ap_clk         (ap_clk),
      .ap_rst         (ap_rst),
      .fifo_count     (fifo_count),
      .in0_V_V_TDATA  (in0_tdata),
      .in0_V_V_TVALID (in0_tvalid),
      .in0_V_V_TREADY (in0_tready),
      .in1_V_V_TDATA  (in1_tdata),
      .in1_V_V_TVALID (in1_tvalid),
      .in1_V_V_TREADY (in1_tready),
      .out_V_V_TDATA  (out_tdata),
      .out_V_V_TVALID (out_tvalid),
      .out_V_V_TREADY (out_tready),
      .grant          (grant),
      .state_dbg_o    (state_dbg)
`ifdef STREAM_FIFO_ARB_STATS_EN
      ,
      .beats0         (beats0),
      .beats1         (beats1)
`endif
   );

   // scoreboard and sources
   int               n_cmp = 0;
   int               n_fail = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] src0[$];
   logic [WIDTH-1:0] src1[$];
   logic             hs0, hs1;
   run_t             runs[$];
   run_t             exp_runs[$];
   run_t             cur;
   vec_t             vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic drive_src();
      in0_tvalid = (src0.size() != 0);
      in0_tdata  = (src0.size() != 0) ? src0[0] : '0;
      in1_tvalid = (src1.size() != 0);
      in1_tdata  = (src1.size() != 0) ? src1[0] : '0;
   endtask

   task automatic clear_log();
      runs.delete();
      cur.g      = 2'b00;
      cur.cycles = 0;
      cur.beats  = 0;
   endtask

   task automatic flush_log();
      if (cur.cycles > 0) runs.push_back(cur);
      cur.cycles = 0;
      cur.beats  = 0;
   endtask

   task automatic add_run(input logic [1:0] g, input int cycles, input int beats);
      run_t r;
      r.g      = g;
      r.cycles = cycles;
      r.beats  = beats;
      exp_runs.push_back(r);
   endtask

   // One clock cycle: sample at negedge, advance sources after posedge
   task automatic tick();
      logic [WIDTH-1:0] e;
      @(negedge ap_clk);
      hs0 = in0_tvalid && in0_tready;
      hs1 = in1_tvalid && in1_tready;
      if (out_tvalid && out_tready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL out_unexpected: got beat %0h required none", out_tdata);
         end else begin
            e = exp_q.pop_front();
            check("out_data", out_tdata, e);
         end
      end
      if (grant != cur.g) begin
         if (cur.cycles > 0) runs.push_back(cur);
         cur.g      = grant;
         cur.cycles = 0;
         cur.beats  = 0;
      end
      cur.cycles++;
      if (hs0 || hs1) cur.beats++;
      @(posedge ap_clk);
      #1;
      if (hs0) void'(src0.pop_front());
      if (hs1) void'(src1.pop_front());
      drive_src();
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((src0.size() != 0 || src1.size() != 0 || exp_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s timeout: %0d beats still expected after %0d cycles", tag, exp_q.size(), n);
         src0.delete();
         src1.delete();
         exp_q.delete();
         drive_src();
      end
   endtask

   task automatic compare_runs(input string tag);
      int k = 0;
      while (k < runs.size() && runs[k].g == 2'b00) k++;
      for (int i = 0; i < exp_runs.size(); i++) begin
         if (k + i >= runs.size()) begin
            check($sformatf("%s run count", tag), runs.size(), k + exp_runs.size());
            break;
         end
         check($sformatf("%s run%0d grant", tag, i), runs[k+i].g, exp_runs[i].g);
         check($sformatf("%s run%0d beats", tag, i), runs[k+i].beats, exp_runs[i].beats);
         if (exp_runs[i].cycles >= 0)
            check($sformatf("%s run%0d cycles", tag, i), runs[k+i].cycles, exp_runs[i].cycles);
      end
   endtask

   task automatic do_reset();
      ap_rst = 1'b1;
      src0.delete();
      src1.delete();
      drive_src();
      out_tready = 1'b1;
      fifo_count = '0;
      repeat (2) tick();
      exp_q.delete();
      ap_rst = 1'b0;
      clear_log();
   endtask

   initial begin
      int n;
      int h;

      // throttle / backpressure vectors, applied in G0 with out TVALID=1
      vecs[0] = '{14'd0,     1'b1, 1'b1, 1'b0, 2'b01};
      vecs[1] = '{14'd16379, 1'b1, 1'b1, 1'b0, 2'b01};
      vecs[2] = '{14'd16380, 1'b1, 1'b0, 1'b0, 2'b01};
      vecs[3] = '{14'd16383, 1'b1, 1'b0, 1'b0, 2'b01};
      vecs[4] = '{14'd16379, 1'b0, 1'b0, 1'b0, 2'b01};
      vecs[5] = '{14'd0,     1'b0, 1'b0, 1'b0, 2'b01};
      vecs[6] = '{14'd100,   1'b1, 1'b1, 1'b0, 2'b01};
      vecs[7] = '{14'd16381, 1'b0, 1'b0, 1'b0, 2'b01};

      clear_log();
      in0_tvalid = 1'b1;
      in1_tvalid = 1'b1;
      #1 ap_rst = 1'b1;
      #1;
      check("rst out_tvalid", out_tvalid, 0);
      check("rst out_tdata", out_tdata, 0);
      check("rst grant", grant, 2'b00);
      check("rst in0_tready", in0_tready, 0);
      check("rst in1_tready", in1_tready, 0);
      check("rst state", state_dbg, 2'b00);

      // only in0, 40 beats: 16 / 16 / 8 with one idle cycle between
      do_reset();
      for (int i = 0; i < 40; i++) begin
         src0.push_back(8'(i));
         exp_q.push_back(8'(i));
      end
      drive_src();
      drain("t030", 400);
      repeat (3) tick();
      flush_log();
      exp_runs.delete();
      add_run(2'b01, 16, 16);
      add_run(2'b00, 1, 0);
      add_run(2'b01, 16, 16);
      add_run(2'b00, 1, 0);
      add_run(2'b01, 9, 8);
      add_run(2'b00, -1, 0);
      compare_runs("t030");

      // throttle threshold table, then throttle hold / resume
      do_reset();
      for (int i = 0; i < 24; i++) begin
         src0.push_back(8'(192 + i));
         exp_q.push_back(8'(192 + i));
      end
      drive_src();
      n = 0;
      while (grant != 2'b01 && n < 10) begin
         tick();
         n++;
      end
      check("t032 reach G0", grant, 2'b01);
      tick();
      clk_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         fifo_count = vecs[i].fc;
         out_tready = vecs[i].ordy;
         #1;
         check($sformatf("vec%0d in0_tready", i), in0_tready, vecs[i].exp_r0);
         check($sformatf("vec%0d in1_tready", i), in1_tready, vecs[i].exp_r1);
         check($sformatf("vec%0d grant", i), grant, vecs[i].exp_grant);
      end
      fifo_count = 14'd16380;
      out_tready = 1'b1;
      clk_en     = 1'b1;
      repeat (3) begin
         tick();
         check("t032 throttled hs", hs0, 0);
         check("t032 throttled tready", in0_tready, 0);
         check("t032 throttled grant", grant, 2'b01);
      end
      fifo_count = 14'd16379;
      #1;
      check("t032 resume tready", in0_tready, 1);
      tick();
      check("t032 resume hs", hs0, 1);
      fifo_count = '0;
      drain("t032", 200);

      // output stall of 5 cycles holding 0xA5
      do_reset();
      out_tready = 1'b0;
      src0.push_back(8'hA5);
      src0.push_back(8'h5A);
      src0.push_back(8'h3C);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h3C);
      drive_src();
      n = 0;
      while (!out_tvalid && n < 10) begin
         tick();
         n++;
      end
      check("t033 valid", out_tvalid, 1);
      repeat (5) begin
         tick();
         check("t033 hold data", out_tdata, 8'hA5);
         check("t033 hold valid", out_tvalid, 1);
         check("t033 in0_tready", in0_tready, 0);
         check("t033 in1_tready", in1_tready, 0);
      end
      out_tready = 1'b1;
      drain("t033", 50);
      repeat (3) tick();

      // both valid: G0, G1, G0, G1 of 16 beats, requester 0 first
      do_reset();
      for (int i = 0; i < 32; i++) begin
         src0.push_back(8'(i));
         src1.push_back(8'(128 + i));
      end
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(128 + i));
      for (int i = 16; i < 32; i++) exp_q.push_back(8'(i));
      for (int i = 16; i < 32; i++) exp_q.push_back(8'(128 + i));
      drive_src();
      drain("t031", 400);
      repeat (3) tick();
      flush_log();
      exp_runs.delete();
      add_run(2'b01, 16, 16);
      add_run(2'b10, 16, 16);
      add_run(2'b01, 16, 16);
      add_run(2'b10, 16, 16);
      add_run(2'b00, -1, 0);
      compare_runs("t031");
`ifdef STREAM_FIFO_ARB_STATS_EN
      check("t035 beats0", beats0, 32);
      check("t035 beats1", beats1, 32);
`endif

      // reset after beat 7 of a G1 burst
      do_reset();
      for (int i = 0; i < 20; i++) src1.push_back(8'(64 + i));
      for (int i = 0; i < 6; i++) exp_q.push_back(8'(64 + i));
      drive_src();
      n = 0;
      h = 0;
      while (h < 7 && n < 40) begin
         tick();
         if (hs1) h++;
         n++;
      end
      check("t034 beats before reset", h, 7);
      check("t034 grant before reset", grant, 2'b10);
      ap_rst = 1'b1;
      #1;
      check("t034 rst out_tvalid", out_tvalid, 0);
      check("t034 rst out_tdata", out_tdata, 0);
      check("t034 rst grant", grant, 2'b00);
      check("t034 rst in0_tready", in0_tready, 0);
      check("t034 rst in1_tready", in1_tready, 0);
      check("t034 pending beats", exp_q.size(), 0);
      src1.delete();
      for (int i = 0; i < 4; i++) begin
         src0.push_back(8'(208 + i));
         src1.push_back(8'(224 + i));
      end
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(208 + i));
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(224 + i));
      drive_src();
      tick();
      ap_rst = 1'b0;
      clear_log();
      n = 0;
      while (grant == 2'b00 && n < 10) begin
         tick();
         n++;
      end
      check("t034 first grant", grant, 2'b01);
      drain("t034", 100);
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
